// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and whatever drives its line and consumes its words.
// DataValid/ParErr/StpErr are single-cycle strobes with no ready: the consumer must take PData on the DataValid cycle.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RxIn;
    logic                  ParityEn;
    logic                  ParityType;
    logic [DATA_WIDTH-1:0] PData;
    logic                  DataValid;
    logic                  ParErr;
    logic                  StpErr;
    logic                  Busy;
    logic [2:0]            dbg_state;

    modport master (
        output RxIn, ParityEn, ParityType,
        input  PData, DataValid, ParErr, StpErr, Busy, dbg_state
    );

    modport slave (
        input  RxIn, ParityEn, ParityType,
        output PData, DataValid, ParErr, StpErr, Busy, dbg_state
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, 2-of-3 majority vote per bit,
// optional even/odd parity and stop-bit checking, registered outputs.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] E_S0   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] E_S1   = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] E_S2   = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] E_ONE  = EW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_type_q, par_type_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  busy_q, busy_d;
    logic                  samp2;
    logic                  voted;

    // With OVERSAMPLE = 4 the third sample point is also the decision point, so take it live.
    assign samp2 = (edge_q == E_S2) ? rx_s_q : samp_q[2];
    assign voted = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp2) | (samp_q[1] & samp2);

    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.RxIn;
        rx_s_d     = sync1_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_bad_d  = par_bad_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != S_IDLE) begin
            edge_d = (edge_q == E_LAST) ? '0 : edge_q + 1'b1;
            if (edge_q == E_S0) samp_d[0] = rx_s_q;
            if (edge_q == E_S1) samp_d[1] = rx_s_q;
            if (edge_q == E_S2) samp_d[2] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                // The detection cycle is edge 0 of the start bit.
                if (!rx_s_q) begin
                    state_d    = S_START;
                    edge_d     = E_ONE;
                    bit_d      = '0;
                    par_bad_d  = 1'b0;
                    par_en_d   = bus.ParityEn;
                    par_type_d = bus.ParityType;
                end
            end
            S_START: begin
                if (edge_q == E_LAST) begin
                    state_d = voted ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (edge_q == E_LAST) begin
                    shift_d = {voted, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == B_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (edge_q == E_LAST) begin
                    par_bad_d = voted ^ (^shift_q) ^ par_type_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (edge_q == E_LAST) begin
                    state_d = S_IDLE;
                    se_d    = ~voted;
                    pe_d    = par_bad_q;
                    if (voted && !par_bad_q) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            edge_q     <= '0;
            bit_q      <= '0;
            samp_q     <= 3'b111;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_bad_q  <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rx_s_q     <= rx_s_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_bad_q  <= par_bad_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.PData     = pdata_q;
    assign bus.DataValid = dv_q;
    assign bus.ParErr    = pe_q;
    assign bus.StpErr    = se_q;
    assign bus.Busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-level frames on RxIn, pulse timing, error strobes and reset.
module tb_uart_rx;
    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.DATA_WIDTH(W)) bus ();

    uart_rx #(.DATA_WIDTH(W), .OVERSAMPLE(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] dv_data_q[$];
    int         dv_cyc_q[$];
    int         pe_cyc_q[$];
    int         se_cyc_q[$];
    int         busy_cnt = 0;
    int         long_cnt = 0;
    logic       dv_prev = 1'b0, pe_prev = 1'b0, se_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observer: every strobe is logged with the cycle it was seen in.
    always @(negedge clk) begin
        if (bus.DataValid) begin
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(bus.PData);
        end
        if (bus.ParErr) pe_cyc_q.push_back(cyc);
        if (bus.StpErr) se_cyc_q.push_back(cyc);
        if ((bus.DataValid && dv_prev) || (bus.ParErr && pe_prev) || (bus.StpErr && se_prev))
            long_cnt++;
        dv_prev = bus.DataValid;
        pe_prev = bus.ParErr;
        se_prev = bus.StpErr;
        if (bus.Busy) busy_cnt++;
    end

    task automatic clear_obs();
        dv_cyc_q.delete();
        dv_data_q.delete();
        pe_cyc_q.delete();
        se_cyc_q.delete();
        exp_q.delete();
        busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            bus.RxIn = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pen, input logic pbit,
                              input logic stop, input logic noise, output int fall);
        int nb;
        nb = W + 2 + (pen ? 1 : 0);
        fall = 0;
        bus.ParityEn = pen;
        for (int i = 0; i < nb; i++) begin
            logic b;
            if (i == 0)                 b = 1'b0;
            else if (i <= W)            b = d[i-1];
            else if (pen && i == W + 1) b = pbit;
            else                        b = stop;
            for (int j = 0; j < N; j++) begin
                @(posedge clk);
                #1;
                bus.RxIn = (noise && i >= 1 && i <= W && j == N/2 - 1 + (i % 3)) ? ~b : b;
                if (i == 0 && j == 0) fall = cyc;
            end
        end
    endtask

    task automatic check_words(input string tag);
        check({tag, "_dv_count"}, dv_data_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < dv_data_q.size(); k++)
            check({tag, "_pdata"}, dv_data_q[k], exp_q[k]);
    endtask

    initial begin
        int fall, fall2;
        bus.RxIn = 1'b1;
        bus.ParityEn = 1'b0;
        bus.ParityType = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pdata", bus.PData, 0);
        check("rst_dv", bus.DataValid, 0);
        check("rst_pe", bus.ParErr, 0);
        check("rst_se", bus.StpErr, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_state", bus.dbg_state, 0);
        rst = 1'b0;
        idle(4);

        // No parity, 0xA5: pulse 80 cycles after rx_s falls (82 after the pin).
        clear_obs();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        idle(3 * N);
        check_words("nopar");
        if (dv_cyc_q.size() > 0) check("nopar_latency", dv_cyc_q[0] - fall, 82);
        check("nopar_busy", busy_cnt, 79);
        check("nopar_pe", pe_cyc_q.size(), 0);
        check("nopar_se", se_cyc_q.size(), 0);

        // Even parity, 0x3C has four ones so parity bit 0 is correct.
        clear_obs();
        bus.ParityType = 1'b0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, fall);
        idle(3 * N);
        check_words("evenok");
        if (dv_cyc_q.size() > 0) check("evenok_latency", dv_cyc_q[0] - fall, 90);
        check("evenok_busy", busy_cnt, 87);

        clear_obs();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, fall);
        idle(3 * N);
        check_words("evenbad");
        check("evenbad_pe", pe_cyc_q.size(), 1);
        check("evenbad_se", se_cyc_q.size(), 0);
        check("evenbad_hold", bus.PData, 8'h3C);

        // Odd parity, 0x01 with parity 0 is correct; stop bit forced low.
        clear_obs();
        bus.ParityType = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, fall);
        idle(3 * N);
        check_words("stp");
        check("stp_se", se_cyc_q.size(), 1);
        check("stp_pe", pe_cyc_q.size(), 0);
        check("stp_hold", bus.PData, 8'h3C);

        clear_obs();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, fall);
        idle(3 * N);
        check_words("both");
        check("both_se", se_cyc_q.size(), 1);
        check("both_pe", pe_cyc_q.size(), 1);
        if (se_cyc_q.size() > 0 && pe_cyc_q.size() > 0)
            check("both_same_cycle", pe_cyc_q[0], se_cyc_q[0]);
        check("both_hold", bus.PData, 8'h3C);

        // Three-cycle low pulse: rejected as a glitch, Busy for the start window only.
        clear_obs();
        bus.ParityType = 1'b0;
        bus.ParityEn = 1'b0;
        @(posedge clk);
        #1 bus.RxIn = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.RxIn = 1'b1;
        idle(3 * N);
        check_words("glitch");
        check("glitch_busy", busy_cnt, N - 1);
        check("glitch_pe", pe_cyc_q.size(), 0);
        check("glitch_se", se_cyc_q.size(), 0);
        clear_obs();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        idle(3 * N);
        check_words("after_glitch");

        // One corrupted sample point per data bit is outvoted.
        clear_obs();
        exp_q.push_back(8'hC6);
        send_frame(8'hC6, 1'b0, 1'b0, 1'b1, 1'b1, fall);
        idle(3 * N);
        check_words("noise");
        check("noise_err", pe_cyc_q.size() + se_cyc_q.size(), 0);

        // Back-to-back frames with no idle gap.
        clear_obs();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, fall2);
        idle(3 * N);
        check_words("b2b");
        if (dv_cyc_q.size() > 1) check("b2b_spacing", dv_cyc_q[1] - dv_cyc_q[0], 80);

        // Reset during data bit 4; bits 4..7 of 0xF3 are high so the line stays idle afterwards.
        clear_obs();
        fork
            send_frame(8'hF3, 1'b0, 1'b0, 1'b1, 1'b0, fall);
            begin
                repeat (5 * N + 6) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("midrst_pdata", bus.PData, 0);
                check("midrst_busy", bus.Busy, 0);
                check("midrst_dv", bus.DataValid, 0);
                check("midrst_pe", bus.ParErr, 0);
                check("midrst_se", bus.StpErr, 0);
                check("midrst_state", bus.dbg_state, 0);
                rst = 1'b0;
            end
        join
        idle(3 * N);
        check_words("midrst");
        check("midrst_err", pe_cyc_q.size() + se_cyc_q.size(), 0);
        clear_obs();
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, fall);
        idle(3 * N);
        check_words("after_rst");
        if (dv_cyc_q.size() > 0) check("after_rst_latency", dv_cyc_q[0] - fall, 82);

        check("pulse_width", long_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive end of the UART-TX link. It oversamples `RxIn`, detects and validates the start bit, and majority-votes each data bit. It then checks optional parity and the stop bit, and presents the received byte as a parallel word with a one-cycle `DataValid` strobe. The frame format matches the transmitter: idle-high line, start 0, `DATA_WIDTH` data bits LSB first, optional parity, one stop bit at 1.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 8: CLK cycles per bit. Must be even and ≥ 4.
- `CLK` input, 1 bit: the only clock. Every flop is rising-edge.
- `RST` input, 1 bit: reset. Synchronous, active-high.
- `RxIn` input, 1 bit: serial line. Asynchronous to CLK. Idles at 1.
- `ParityEn` input, 1 bit: 1 means a parity bit follows the data.
- `ParityType` input, 1 bit: 0 selects even parity, 1 selects odd.
- `PData` output, `DATA_WIDTH` bits: last good received word.
- `DataValid` output, 1 bit: one-cycle pulse when `PData` is updated.
- `ParErr` output, 1 bit: one-cycle pulse when the parity check fails.
- `StpErr` output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
- `Busy` output, 1 bit: high while a frame is in progress.

## Operation
- **Input synchronizer.** `RxIn` passes through a 2-flop synchronizer that resets to 1. The output is `rx_s`. All logic below uses `rx_s`.
- **Counters.**
  - `EdgeCnt` runs 0 to `OVERSAMPLE`-1 within a bit.
  - `BitCnt` runs 0 to `DATA_WIDTH`-1 in the Data state.
- **Sampling.** Each bit is sampled at `EdgeCnt` = N/2-1, N/2 and N/2+1, where N = `OVERSAMPLE`. The bit value is the 2-of-3 majority. It is used at `EdgeCnt` = N-1.
- **States:** IDLE, Start, Data, Parity, Stop.
  - **IDLE.** When `rx_s` = 0, go to Start. That detection cycle counts as `EdgeCnt` 0. Latch `ParityEn` and `ParityType` in the same cycle; later changes to them do not affect the frame in progress.
  - **Start.** At `EdgeCnt` = N-1:
    - If the voted bit is 1, treat it as a glitch. Return to IDLE with no output pulses.
    - Otherwise go to Data.
  - **Data.** At each `EdgeCnt` = N-1, shift the voted bit into the MSB of the shift register, so the LSB arrives first. After bit `DATA_WIDTH`-1, go to Parity if the latched `ParityEn` is 1, otherwise to Stop.
  - **Parity.** At `EdgeCnt` = N-1, compare the voted bit with the expected value: XOR of the data bits, XOR the latched `ParityType`. Record a mismatch. Go to Stop.
  - **Stop.** At `EdgeCnt` = N-1, go to IDLE. In the next cycle:
    - If the voted stop bit is 0, pulse `StpErr`.
    - If a parity mismatch was recorded, pulse `ParErr`.
    - If neither error occurred, load `PData` from the shift register and pulse `DataValid`.
- **Errors.** `ParErr` and `StpErr` may pulse in the same cycle. A frame with any error leaves `PData` unchanged.
- **Busy.** High in Start, Data, Parity and Stop. Low in IDLE, including the cycle that carries the output pulses.
- **Back-to-back frames.** A new start bit may be detected in the same IDLE cycle that carries the previous frame's pulses.
- **Reset.** `RST` high at a clock edge, at any point including mid-frame, does the following:
  - State returns to IDLE and all counters clear.
  - The synchronizer is set to 1.
  - `PData` = 0, `DataValid` = 0, `ParErr` = 0, `StpErr` = 0, `Busy` = 0.
  - The frame in progress is discarded and produces no pulses.

## Timing
- All outputs are registered.
- Frame length is F = (2 + `DATA_WIDTH` + `ParityEn`) × N cycles.
- Let cycle 0 be the first cycle in which `rx_s` = 0.
  - The output pulse appears in cycle F.
  - `Busy` is high from cycle 1 through cycle F-1.
- Pin-to-`rx_s` latency is 2 cycles. An ideal frame driven on `RxIn` therefore produces `DataValid` F+2 cycles after the falling edge.
- Pulses last exactly 1 cycle.
- A low of N/2-1 cycles or less in `rx_s` starting from IDLE never produces a frame.

## Test plan
- **No parity.** N = 8, `ParityEn` = 0, send 0xA5 → `DataValid` for 1 cycle 80 cycles after `rx_s` falls. `PData` = 0xA5, no error pulses. `Busy` is high for 79 cycles.
- **Even parity, both outcomes.** `ParityEn` = 1, `ParityType` = 0:
  - Send 0x3C with parity 0 → `DataValid` at cycle 88, `PData` = 0x3C.
  - Repeat with parity bit 1 → `ParErr` pulses, no `DataValid`, `PData` stays 0x3C.
- **Bad stop bit.** `ParityType` = 1 (odd), send 0x01 with parity 0 and stop bit 0 → `StpErr` only, `PData` unchanged.
  - Variant with a wrong parity bit as well → `ParErr` and `StpErr` pulse in the same cycle.
- **Start glitch.** `RxIn` low for 3 cycles, then high → no pulses, `Busy` drops at the end of the start-bit window, the next real frame is received correctly.
  - Per-sample noise: flip one of the three sample points on each data bit → the data is still received correctly.
- **Back-to-back.** Send 0x55 then 0xAA with no idle gap between stop and start → two `DataValid` pulses 80 cycles apart, `PData` equal to 0x55 and then 0xAA.
- **Reset mid-frame.** Assert `RST` for 1 cycle during data bit 4 → all outputs 0 on the next cycle, no pulse for the aborted frame, the following frame is received correctly.
